// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: walks latched A/B vectors lane by lane through a shared
// scalar ALU, while letting scalar requests borrow it with bounded starvation.
// Ports: clk/rst; req_valid/req_ready/ALUControlV/A/B request; scalar_valid,
// scalar_a/b/ctrl, scalar_grant/scalar_result; alu_a/b/ctrl, alu_result;
// Out_v, done, busy, lane_idx.
module vector_alu_sequencer #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8,
  localparam int LW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [2:0]                          ALUControlV,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  A,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  B,
  input  logic                                scalar_valid,
  input  logic [WIDTH-1:0]                    scalar_a,
  input  logic [WIDTH-1:0]                    scalar_b,
  input  logic [2:0]                          scalar_ctrl,
  output logic                                scalar_grant,
  output logic [WIDTH-1:0]                    scalar_result,
  output logic [WIDTH-1:0]                    alu_a,
  output logic [WIDTH-1:0]                    alu_b,
  output logic [2:0]                          alu_ctrl,
  input  logic [WIDTH-1:0]                    alu_result,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  Out_v,
  output logic                                done,
  output logic                                busy,
  output logic [LW-1:0]                       lane_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0] LAST = LW'(VECTOR_WIDTH - 1);

  state_t state, state_n;

  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] a_lat;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] b_lat;
  logic [2:0]                         ctrl_lat;
  logic [2:0]                         starve_cnt;
  logic                               vec_cycle;

  // After four back-to-back scalar wins in RUN the vector lane is forced.
  assign scalar_grant = scalar_valid &&
                        !(state == RUN && starve_cnt == 3'd4);
  assign vec_cycle    = (state == RUN) && !scalar_grant;
  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = RUN;
      RUN:     if (vec_cycle && lane_idx == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_ctrl      = '0;
    scalar_result = '0;
    unique case (1'b1)
      scalar_grant: begin
        alu_a         = scalar_a;
        alu_b         = scalar_b;
        alu_ctrl      = scalar_ctrl;
        scalar_result = alu_result;
      end
      vec_cycle: begin
        alu_a    = a_lat[lane_idx];
        alu_b    = b_lat[lane_idx];
        alu_ctrl = ctrl_lat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane_idx   <= '0;
      starve_cnt <= '0;
      Out_v      <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      ctrl_lat   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          starve_cnt <= '0;
          if (req_valid) begin
            a_lat    <= A;
            b_lat    <= B;
            ctrl_lat <= ALUControlV;
            lane_idx <= '0;
          end
        end
        RUN: begin
          if (scalar_grant) begin
            starve_cnt <= starve_cnt + 3'd1;
          end else begin
            starve_cnt      <= '0;
            Out_v[lane_idx] <= alu_result;
            lane_idx <= (lane_idx == LAST) ? '0 : lane_idx + LW'(1);
          end
        end
        default: starve_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Testbench for vector_alu_sequencer: scoreboard of expected vector results
// plus a cycle-level reference model checking handshake and arbitration.
module tb_vector_alu_sequencer;

  localparam int W  = 24;
  localparam int VW = 8;
  localparam int LW = 3;

  typedef logic [VW-1:0][W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    ALUControlV;
  vec_t          A, B, Out_v;
  logic          scalar_valid;
  logic [W-1:0]  scalar_a, scalar_b, scalar_result;
  logic [2:0]    scalar_ctrl;
  logic          scalar_grant;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]    alu_ctrl;
  logic          done, busy;
  logic [LW-1:0] lane_idx;

  int n_cmp = 0;
  int n_bad = 0;

  vector_alu_sequencer #(.WIDTH(W), .VECTOR_WIDTH(VW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .ALUControlV(ALUControlV), .A(A), .B(B),
    .scalar_valid(scalar_valid), .scalar_a(scalar_a),
    .scalar_b(scalar_b), .scalar_ctrl(scalar_ctrl),
    .scalar_grant(scalar_grant), .scalar_result(scalar_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .Out_v(Out_v), .done(done), .busy(busy), .lane_idx(lane_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(logic [W-1:0] a,
                                          logic [W-1:0] b,
                                          logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (a < b) ? W'(1) : W'(0);
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);

  function automatic vec_t vec_fn(vec_t a, vec_t b, logic [2:0] c);
    vec_t r;
    for (int i = 0; i < VW; i++) r[i] = alu_fn(a[i], b[i], c);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < VW; i++) r[i] = W'($urandom());
    return r;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  vec_t exp_q[$];
  bit   mon_on = 0;
  int   cyc = 0, acc_cyc = 0, done_cyc = 0, last_lat = 0, done_cnt = 0;

  // Reference model: 0 idle, 1 run, 2 done.
  int m_st = 0, m_lane = 0, m_streak = 0;
  bit m_rst_chk = 1;

  always @(negedge clk) begin
    if (mon_on) begin
      bit   eg;
      vec_t e;
      cyc++;
      eg = scalar_valid && !(m_st == 1 && m_streak == 4);
      chk("ready", req_ready, m_st == 0);
      chk("busy", busy, m_st != 0);
      chk("done", done, m_st == 2);
      chk("grant", scalar_grant, eg);
      chk("lane", lane_idx, m_lane);
      if (eg)
        chk("scalar_res", scalar_result,
            alu_fn(scalar_a, scalar_b, scalar_ctrl));
      else
        chk("scalar_zero", scalar_result, 0);
      if (!eg && m_st != 1)
        chk("alu_idle", {alu_a, alu_b, alu_ctrl}, 0);
      if (m_rst_chk) begin
        chk("out_reset", Out_v, 0);
        m_rst_chk = 0;
      end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (done) begin
        done_cnt++;
        last_lat = cyc - acc_cyc;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_v", Out_v, e);
        end
      end
      if (rst) begin
        m_st = 0; m_lane = 0; m_streak = 0; m_rst_chk = 1;
      end else begin
        case (m_st)
          0: if (req_valid) begin
            m_st = 1; m_lane = 0; m_streak = 0;
          end
          1: if (eg) m_streak++;
          else begin
            m_streak = 0;
            if (m_lane == VW - 1) begin m_st = 2; m_lane = 0; end
            else m_lane++;
          end
          default: begin m_st = 0; m_streak = 0; end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(vec_t a, vec_t b, logic [2:0] c, bit hold);
    bit ok = 0;
    A = a; B = b; ALUControlV = c; req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(vec_fn(a, b, c));
        ok = 1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(int limit);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < limit) begin
      tick();
      i++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic rand_scalar();
    scalar_a    = W'($urandom());
    scalar_b    = W'($urandom());
    scalar_ctrl = 3'($urandom());
  endtask

  bit stop_sc = 0;

  initial begin
    vec_t va, vb, ve;
    int d0;
    rst = 1'b1; req_valid = 1'b0; ALUControlV = '0; A = '0; B = '0;
    scalar_valid = 1'b0; scalar_a = '0; scalar_b = '0; scalar_ctrl = '0;
    repeat (3) tick();
    mon_on = 1; rst = 1'b0;

    // Add, no scalar traffic.
    for (int i = 0; i < VW; i++) begin
      va[i] = W'(i + 1);
      ve[i] = W'(2 * (i + 1));
    end
    send(va, va, 3'd0, 0);
    wait_done(50);
    chk("add_lat", last_lat, 9);
    chk("add_out", Out_v, ve);

    // Two scalar cycles mid-run.
    tick();
    send(rand_vec(), rand_vec(), 3'd1, 0);
    tick(); tick();
    scalar_valid = 1'b1; rand_scalar();
    tick(); rand_scalar();
    tick(); scalar_valid = 1'b0;
    wait_done(50);
    chk("interleave_lat", last_lat, 11);

    // Continuous scalar pressure.
    tick();
    scalar_valid = 1'b1; rand_scalar();
    d0 = done_cnt;
    send(rand_vec(), rand_vec(), 3'd4, 0);
    for (int i = 0; i < 100 && done_cnt == d0; i++) begin
      rand_scalar();
      tick();
    end
    scalar_valid = 1'b0;
    chk("starve_done", done_cnt, d0 + 1);
    chk("starve_lat", last_lat, 41);

    // Request while busy is ignored.
    tick();
    va = rand_vec(); vb = rand_vec();
    send(va, vb, 3'd3, 0);
    tick();
    for (int i = 0; i < VW; i++) A[i] = '1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_done(50);
    chk("busy_out", Out_v, vec_fn(va, vb, 3'd3));

    // Reset after lane 3 captured.
    tick();
    send(rand_vec(), rand_vec(), 3'd2, 0);
    repeat (4) tick();
    chk("pre_rst_lane", lane_idx, 4);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    repeat (12) tick();
    chk("rst_no_done", done_cnt, d0);
    va = rand_vec(); vb = rand_vec();
    send(va, vb, 3'd5, 0);
    wait_done(50);
    chk("rst_fresh_lat", last_lat, 9);
    chk("rst_fresh_out", Out_v, vec_fn(va, vb, 3'd5));

    // Back-to-back with req_valid held.
    tick();
    send(rand_vec(), rand_vec(), 3'd0, 1);
    for (int k = 0; k < 2; k++) begin
      send(rand_vec(), rand_vec(), 3'(k + 6), 1);
      chk("b2b_gap", acc_cyc - done_cyc, 1);
    end
    req_valid = 1'b0;
    wait_done(50);

    // Random traffic with a free-running scalar requester.
    tick();
    fork
      begin
        while (!stop_sc) begin
          scalar_valid = ($urandom_range(0, 2) != 0);
          rand_scalar();
          tick();
        end
        scalar_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 20; n++) begin
          send(rand_vec(), rand_vec(), 3'($urandom()), 0);
          wait_done(200);
          repeat ($urandom_range(0, 3)) tick();
        end
        stop_sc = 1;
      end
    join
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 24, element width in bits.
REQ-002 Parameter VECTOR_WIDTH, default 8, lanes per vector operation.
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  vector request present; req_ready  out  1  sequencer can accept.
REQ-007 ALUControlV  in  3  vector op code; A, B  in  VECTOR_WIDTH x WIDTH  vector operands.
REQ-008 scalar_valid  in  1  scalar ALU request; scalar_a, scalar_b  in  WIDTH; scalar_ctrl  in  3.
REQ-009 scalar_grant  out  1  scalar request owns the ALU this cycle; scalar_result  out  WIDTH.
REQ-010 alu_a, alu_b  out  WIDTH; alu_ctrl  out  3  operands and op to the shared scalar ALU.
REQ-011 alu_result  in  WIDTH  combinational ALU result for the current alu_a/alu_b/alu_ctrl.
REQ-012 Out_v  out  VECTOR_WIDTH x WIDTH  registered vector result; done  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  vector operation in progress; lane_idx  out  clog2(VECTOR_WIDTH)  current lane.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE, and busy SHALL be 1 only in RUN or DONE.
REQ-016 IDLE: on req_valid && req_ready at an edge, A, B and ALUControlV SHALL be latched, lane_idx SHALL be set to 0, and the next state SHALL be RUN.
REQ-017 Requests presented while req_ready=0 SHALL be ignored and SHALL not alter latched operands.
REQ-018 RUN, vector cycle (scalar_grant=0): alu_a = A_lat[lane_idx], alu_b = B_lat[lane_idx], alu_ctrl = ctrl_lat; at the edge, Out_v[lane_idx] <= alu_result and lane_idx increments.
REQ-019 RUN, scalar cycle (scalar_grant=1): lane_idx and Out_v SHALL hold.
REQ-020 Capturing lane VECTOR_WIDTH-1 SHALL move the state to DONE and wrap lane_idx to 0.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; lanes of Out_v not yet written SHALL never be exposed with done=1.
REQ-022 Out_v SHALL hold its value from DONE until the next lane capture of a later operation.
REQ-023 scalar_grant = scalar_valid && !(state==RUN && starve_cnt==4).
REQ-024 When scalar_grant=1: alu_a = scalar_a, alu_b = scalar_b, alu_ctrl = scalar_ctrl, scalar_result = alu_result (same cycle, zero latency).
REQ-025 When scalar_grant=0, scalar_result SHALL be 0.
REQ-026 starve_cnt (3 bits) SHALL increment on each RUN cycle with scalar_grant=1 and clear on any RUN vector cycle and in IDLE/DONE.
REQ-027 Consequently, under continuous scalar_valid at most 4 consecutive scalar cycles SHALL occur in RUN before one vector lane is forced.
REQ-028 A denied scalar requester SHALL hold its request; the sequencer SHALL not buffer it.
REQ-029 In IDLE and DONE, scalar requests SHALL always be granted.
REQ-030 With no scalar grants, done SHALL assert exactly VECTOR_WIDTH+1 cycles after the accept edge; each granted scalar cycle in RUN adds one cycle.
REQ-031 Idle ALU outputs (no grant, not RUN): alu_a = alu_b = 0 and alu_ctrl = 0.

Reset
REQ-032 On rst=1 at an edge: state=IDLE, lane_idx=0, starve_cnt=0, Out_v all 0, done=0, busy=0; latched operands SHALL be cleared to 0.
REQ-033 rst SHALL override a simultaneous accept; reset during RUN/DONE SHALL abort the operation with no done pulse.
REQ-034 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-035 Add, no scalar traffic: A=B={1..8}, ALUControlV=000 with an adding ALU model -> done 9 cycles after accept, Out_v={2,4,...,16}, req_ready=0 throughout.
REQ-036 Scalar interleave: scalar_valid=1 for 2 cycles mid-RUN -> scalar_grant=1 and scalar_result correct on those cycles, lane_idx frozen, done at accept+11.
REQ-037 Starvation: scalar_valid held high through RUN -> grant pattern 4 scalar / 1 vector, repeated; all 8 lanes complete and done at accept+41.
REQ-038 Busy rejection: second req_valid with A=24'hFFFFFF pulsed during RUN -> ignored; Out_v reflects the first operands only.
REQ-039 Reset mid-op: rst after lane 3 is captured -> no done, Out_v=0, req_ready=1 the next cycle, and a fresh request completes correctly.
REQ-040 Back-to-back: req_valid held high -> second accept on the cycle after done, Out_v lanes overwritten in order 0..7.
